// File: rtl/ooo_resp_slave.sv
// ooo_resp_slave: memory-backed slave with independent write and read channels.
// Each channel holds up to DEPTH outstanding requests and returns responses out
// of order across IDs but in acceptance order within an ID.
// Optional feature macro: OOO_SLAVE_ERR_RESP_EN. When it is defined, addresses at
// or above MEM_WORDS answer SLVERR (2'b10), the write is dropped and the read
// returns 0. When it is undefined, addresses wrap modulo MEM_WORDS and every
// response is OKAY.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_addr/awid write request;  wr_rdy write slot available
//   wr_resp_valid/wr_resp_id/wr_resp               write response
//   rd_valid/rd_addr/arid         read request;   rd_rdy read slot available
//   rd_resp_valid/rd_resp_id/rd_resp/rd_data       read response

// One response channel: an age-ordered slot queue (index 0 is the oldest).
// Ports: i_push accepted request (already qualified by o_rdy), i_id/i_cnt/i_pay
// slot contents; o_rdy slot free; o_valid/o_id/o_pay registered response.
module ooo_resp_slave_chan #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned PAY_W = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_id,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [PAY_W-1:0] i_pay,
  output logic             o_rdy,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id,
  output logic [PAY_W-1:0] o_pay
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][ID_W-1:0]  r_id;
  logic [DEPTH-1:0][CNT_W-1:0] r_cnt;
  logic [DEPTH-1:0][PAY_W-1:0] r_pay;
  logic                        r_rdy;
  logic                        r_ovalid;
  logic [ID_W-1:0]             r_oid;
  logic [PAY_W-1:0]            r_opay;

  logic [DEPTH-1:0]            w_elig;
  logic                        w_hit;
  logic [IDX_W-1:0]            w_sel;
  logic [ID_W-1:0]             w_sel_id;
  logic [PAY_W-1:0]            w_sel_pay;
  logic [DEPTH-1:0]            w_n_vld;
  logic [DEPTH-1:0][ID_W-1:0]  w_n_id;
  logic [DEPTH-1:0][CNT_W-1:0] w_n_cnt;
  logic [DEPTH-1:0][PAY_W-1:0] w_n_pay;
  logic                        w_placed;

  // A slot may respond once expired and no older slot carries the same ID.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = r_vld[i] && (r_cnt[i] == '0);
      for (int j = 0; j < i; j++) begin
        if (r_vld[j] && (r_id[j] == r_id[i])) w_elig[i] = 1'b0;
      end
    end
  end

  // Oldest eligible slot wins (descending scan leaves the lowest index).
  always_comb begin
    w_hit     = 1'b0;
    w_sel     = '0;
    w_sel_id  = '0;
    w_sel_pay = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_hit     = 1'b1;
        w_sel     = IDX_W'(i);
        w_sel_id  = r_id[i];
        w_sel_pay = r_pay[i];
      end
    end
  end

  // Next slot state: remove the winner and compact, age the counters, append.
  always_comb begin
    w_n_vld  = '0;
    w_n_id   = '0;
    w_n_cnt  = '0;
    w_n_pay  = '0;
    w_placed = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (w_hit && (IDX_W'(i) >= w_sel)) begin
        w_n_vld[i] = r_vld[i+1];
        w_n_id[i]  = r_id[i+1];
        w_n_cnt[i] = r_cnt[i+1];
        w_n_pay[i] = r_pay[i+1];
      end else begin
        w_n_vld[i] = r_vld[i];
        w_n_id[i]  = r_id[i];
        w_n_cnt[i] = r_cnt[i];
        w_n_pay[i] = r_pay[i];
      end
    end
    if (!w_hit) begin
      w_n_vld[DEPTH-1] = r_vld[DEPTH-1];
      w_n_id[DEPTH-1]  = r_id[DEPTH-1];
      w_n_cnt[DEPTH-1] = r_cnt[DEPTH-1];
      w_n_pay[DEPTH-1] = r_pay[DEPTH-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_n_cnt[i] != '0) w_n_cnt[i] = w_n_cnt[i] - CNT_W'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && !w_placed && !w_n_vld[i]) begin
        w_n_vld[i] = 1'b1;
        w_n_id[i]  = i_id;
        w_n_cnt[i] = i_cnt;
        w_n_pay[i] = i_pay;
        w_placed   = 1'b1;
      end
    end
  end

  // Slot state and registered response; ready reflects occupancy after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_pay    <= '0;
      r_rdy    <= 1'b0;
      r_ovalid <= 1'b0;
      r_oid    <= '0;
      r_opay   <= '0;
    end else begin
      r_vld    <= w_n_vld;
      r_id     <= w_n_id;
      r_cnt    <= w_n_cnt;
      r_pay    <= w_n_pay;
      r_rdy    <= ~&w_n_vld;
      r_ovalid <= w_hit;
      r_oid    <= w_sel_id;
      r_opay   <= w_sel_pay;
    end
  end

  assign o_rdy   = r_rdy;
  assign o_valid = r_ovalid;
  assign o_id    = r_oid;
  assign o_pay   = r_opay;
endmodule

module ooo_resp_slave #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_WORDS = 128,
  parameter int unsigned LAT_BASE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ID_W-1:0]   awid,
  output logic              wr_rdy,
  output logic              wr_resp_valid,
  output logic [ID_W-1:0]   wr_resp_id,
  output logic [1:0]        wr_resp,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ID_W-1:0]   arid,
  output logic              rd_rdy,
  output logic              rd_resp_valid,
  output logic [ID_W-1:0]   rd_resp_id,
  output logic [1:0]        rd_resp,
  output logic [DATA_W-1:0] rd_data
);
  localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Countdown is stored minus one so the response registers on the edge it expires.
  localparam int unsigned CNT_W  = $clog2(LAT_BASE + 3);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_err;
  logic              w_rd_err;
  logic [MEM_AW-1:0] w_wr_idx;
  logic [MEM_AW-1:0] w_rd_idx;
  logic [CNT_W-1:0]  w_wr_cnt;
  logic [CNT_W-1:0]  w_rd_cnt;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_pay;
  logic [DATA_W:0]   w_rd_pay;

  assign w_wr_acc = wr_valid & wr_rdy;
  assign w_rd_acc = rd_valid & rd_rdy;
  assign w_wr_idx = MEM_AW'(32'(wr_addr) % MEM_WORDS);
  assign w_rd_idx = MEM_AW'(32'(rd_addr) % MEM_WORDS);
  assign w_wr_cnt = CNT_W'(LAT_BASE - 1) + CNT_W'(wr_addr[1:0]);
  assign w_rd_cnt = CNT_W'(LAT_BASE - 1) + CNT_W'(rd_addr[1:0]);

`ifdef OOO_SLAVE_ERR_RESP_EN
  assign w_wr_err = (32'(wr_addr) >= MEM_WORDS);
  assign w_rd_err = (32'(rd_addr) >= MEM_WORDS);
`else
  assign w_wr_err = 1'b0;
  assign w_rd_err = 1'b0;
`endif

  // Read capture with write-first bypass; errored reads return zero.
  always_comb begin
    w_rd_data = r_mem[w_rd_idx];
    if (w_wr_acc && !w_wr_err && (w_wr_idx == w_rd_idx)) w_rd_data = wr_data;
    if (w_rd_err) w_rd_data = '0;
  end

  // Backing memory, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_wr_acc && !w_wr_err) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  ooo_resp_slave_chan #(
    .ID_W (ID_W), .PAY_W(1), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_wr_chan (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_wr_acc),
    .i_id   (awid),
    .i_cnt  (w_wr_cnt),
    .i_pay  (w_wr_err),
    .o_rdy  (wr_rdy),
    .o_valid(wr_resp_valid),
    .o_id   (wr_resp_id),
    .o_pay  (w_wr_pay)
  );

  ooo_resp_slave_chan #(
    .ID_W (ID_W), .PAY_W(DATA_W + 1), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_rd_chan (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_rd_acc),
    .i_id   (arid),
    .i_cnt  (w_rd_cnt),
    .i_pay  ({w_rd_err, w_rd_data}),
    .o_rdy  (rd_rdy),
    .o_valid(rd_resp_valid),
    .o_id   (rd_resp_id),
    .o_pay  (w_rd_pay)
  );

  assign wr_resp = {w_wr_pay, 1'b0};
  assign rd_resp = {w_rd_pay[DATA_W], 1'b0};
  assign rd_data = w_rd_pay[DATA_W-1:0];
endmodule

// File: doc/ooo_resp_slave.md
OOO_RESP_SLAVE -- requirements
Module: ooo_resp_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width.
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 4, outstanding slots per channel (power of 2, 2..16).
REQ-005 SHALL have parameter MEM_WORDS, default 128, backing memory words (≤ 2^ADDR_W).
REQ-006 SHALL have parameter LAT_BASE, default 1, minimum response latency in cycles (≥1).
REQ-007 SHALL have ports: clk  in  1  single clock, all logic rising-edge; rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have write request ports: wr_valid in 1; wr_data in DATA_W; wr_addr in ADDR_W; awid in ID_W; wr_rdy out 1 (slot available).
REQ-009 SHALL have write response ports: wr_resp_valid out 1; wr_resp_id out ID_W; wr_resp out 2 (00 OKAY, 10 SLVERR).
REQ-010 SHALL have read request ports: rd_valid in 1; rd_addr in ADDR_W; arid in ID_W; rd_rdy out 1.
REQ-011 SHALL have read response ports: rd_resp_valid out 1; rd_resp_id out ID_W; rd_resp out 2; rd_data out DATA_W.

Function
REQ-012 Request SHALL be accepted on a rising edge where valid and rdy are both 1; no response-side backpressure.
REQ-013 wr_rdy/rd_rdy SHALL be 0 when all DEPTH slots of that channel are occupied at the start of the cycle; a slot freed by a response becomes usable the next cycle.
REQ-014 Accepted write SHALL update memory at the acceptance edge; accepted read SHALL capture memory data at the acceptance edge.
REQ-015 Same-edge write and read to the same address SHALL return the new write data (write-first bypass).
REQ-016 Each slot SHALL load a countdown of LAT_BASE + addr[1:0] at acceptance, decrementing by 1 per cycle to 0 (saturating).
REQ-017 Slot SHALL be eligible when countdown is 0 and no older occupied slot in the same channel holds the same ID.
REQ-018 Responses with different IDs SHALL be issued out of order; equal IDs SHALL be issued in acceptance order.
REQ-019 Per channel, at most one response per cycle; among eligible slots, the oldest SHALL win.
REQ-020 Response outputs SHALL be registered, *_resp_valid high exactly one cycle per response, slot freed on the same edge.
REQ-021 Earliest response SHALL appear LAT_BASE + addr[1:0] cycles after the acceptance edge (LAT_BASE=1, addr[1:0]=0: next cycle).
REQ-022 When *_resp_valid is 0, id/resp/data outputs SHALL be 0.
REQ-023 Address SHALL map to memory word addr mod MEM_WORDS unless REQ-029 applies.
REQ-024 Write and read channels SHALL operate independently and concurrently.

Reset
REQ-025 While rst=0: all valid/id/resp/data outputs 0, wr_rdy=0, rd_rdy=0, all slots empty, memory cleared to 0.
REQ-026 First cycle after rst release: wr_rdy=1, rd_rdy=1.
REQ-027 Reset asserted mid-operation SHALL discard all pending slots; no response for them is ever issued.

Configuration
REQ-028 Macro OOO_SLAVE_ERR_RESP_EN SHALL select address error checking.
REQ-029 Defined: addr ≥ MEM_WORDS SHALL give resp=10, write discarded, rd_data=0, latency/ordering unchanged.
REQ-030 Undefined: resp SHALL always be 00 and addresses wrap per REQ-023.

Verification
REQ-031 Write addr 0x03 id 1 then addr 0x00 id 2 on consecutive cycles (LAT_BASE=1) -> id 2 response precedes id 1.
REQ-032 Two writes id 5, addr 0x03 then 0x00 -> responses in order id 5 (first), id 5 (second), second delayed until after first.
REQ-033 Four writes with no response yet (LAT_BASE=8) -> wr_rdy=0 on fifth cycle, 1 again the cycle after the first response.
REQ-034 Same-edge write 0xA5 and read at addr 0x10 -> rd_data=0xA5, rd_resp=00.
REQ-035 With OOO_SLAVE_ERR_RESP_EN, write 0x55 then read at addr 0x80 -> wr_resp=10, rd_resp=10, rd_data=0x00; without macro read returns 0x55 (word 0x00).
REQ-036 Assert rst with 3 reads pending -> no rd_resp_valid after release; rd_rdy=1 first cycle after release.
